dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_bank.sv | 47 ++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and helpers for the data-memory responder
// Purpose: FSM state encoding, bad-read pattern, byte-lane geometry and the
//          lane-merge helper used by the RAM bank's write-first read path.
// Ports:   none (package).
package dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] BAD_READ_DATA = 32'hDEAD_BEEF;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  // Replace the byte lanes selected by mask in old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask[i]) r[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// rtl/dmem_responder_bank.sv - word RAM with byte write mask and one registered read port
// Purpose: 2**ADDR_WIDTH x 32 storage. Writes update only the masked lanes.
//          The read register loads only when re=1, so it holds the last read
//          word otherwise. A read of the word being written in the same cycle
//          returns the merged post-write value (write-first).
// Ports:   clk, rst (sync active-low, clears only the read register),
//          wmask/waddr/wdata (write port), re/raddr (read request), rdata.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            wmask,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] rd_word;

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  // Forward same-cycle write lanes so the read sees the post-write word.
  always_comb begin
    rd_word = mem[raddr];
    if ((|wmask) && (waddr == raddr)) rd_word = merge_lanes(mem[raddr], wdata, wmask);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_word;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder for the MEM stage sram_* port
// Purpose: accepts single-cycle byte-masked writes and fixed-latency reads
//          (1 + WAIT_STATES cycles) with a busy/ack handshake.
// Optional: DMEM_BOUNDS_CHECK_EN enables window checking against BASE_ADDR;
//           out-of-range writes are dropped, reads return 32'hDEAD_BEEF and
//           bus_error pulses the cycle after acceptance. Without it, the
//           address wraps modulo the depth and bus_error is 0.
// Ports:   clk, rst (sync active-low); sram_ren, sram_wen[3:0],
//          sram_address[31:0], sram_data_write[31:0] (requests);
//          sram_data_read[31:0], sram_rack, sram_busy, bus_error (responses).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_ren,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_address,
  input  logic [31:0] sram_data_write,
  output logic [31:0] sram_data_read,
  output logic        sram_rack,
  output logic        sram_busy,
  output logic        bus_error
);

  // Counter value on which the last wait cycle ends.
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] cap_word;
  logic                  idle;
  logic [ADDR_WIDTH-1:0] in_word;
  logic                  in_ok;
  logic                  rd_issue;
  logic [3:0]            bank_wmask;
  logic                  bank_re;
  logic [ADDR_WIDTH-1:0] bank_raddr;
  logic [31:0]           bank_rdata;

  assign idle     = (state == ST_IDLE);
  assign in_word  = sram_address[ADDR_WIDTH+1:2];
  assign rd_issue = idle && sram_ren;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;

  logic [31:0] offset;
  logic        cap_oob;
  logic        rd_oob;
  logic        bus_err_q;

  assign offset = sram_address - BASE_ADDR;
  assign in_ok  = ({1'b0, offset} < WIN_BYTES);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sram_address[31:ADDR_WIDTH+2], sram_address[1:0]};
  assign in_ok = 1'b1;
`endif

  // Writes only land in IDLE; anything presented while busy is dropped.
  assign bank_wmask = (idle && in_ok) ? sram_wen : 4'b0000;

  // The RAM is read on the edge that enters RESP: straight from the request
  // with no wait states, otherwise from the captured word on the last wait.
  assign bank_re    = (rd_issue && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == WS_LAST));
  assign bank_raddr = idle ? in_word : cap_word;

  dmem_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .wmask (bank_wmask),
    .waddr (in_word),
    .wdata (sram_data_write),
    .re    (bank_re),
    .raddr (bank_raddr),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      cap_word <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sram_ren) begin
            cap_word <= in_word;
            wait_cnt <= 4'd0;
            state    <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WS_LAST) begin
            wait_cnt <= 4'd0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sram_rack = (state == ST_RESP);
  assign sram_busy = !idle;

`ifdef DMEM_BOUNDS_CHECK_EN
  // rd_oob loads with the RAM read register so the substituted pattern
  // appears and holds on exactly the same cycles as real read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_oob   <= 1'b0;
      rd_oob    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (rd_issue) cap_oob <= !in_ok;
      if (bank_re)  rd_oob  <= idle ? !in_ok : cap_oob;
      bus_err_q <= idle && (sram_ren || (|sram_wen)) && !in_ok;
    end
  end

  assign sram_data_read = rd_oob ? BAD_READ_DATA : bank_rdata;
  assign bus_error      = bus_err_q;
`else
  assign sram_data_read = bank_rdata;
  assign bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder (WAIT_STATES 0 and 3 side by side)
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sram_ren;
  logic [3:0]  sram_wen;
  logic [31:0] sram_address;
  logic [31:0] sram_data_write;

  logic [31:0] rdata0, rdata3;
  logic        rack0, rack3, busy0, busy3, berr0, berr3;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] model_mem [0:1023];
  logic [31:0] last3;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_address(sram_address), .sram_data_write(sram_data_write),
    .sram_data_read(rdata0), .sram_rack(rack0), .sram_busy(busy0), .bus_error(berr0)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .rst(rst), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_address(sram_address), .sram_data_write(sram_data_write),
    .sram_data_read(rdata3), .sram_rack(rack3), .sram_busy(busy3), .bus_error(berr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a >= 32'h0000_1000;
`else
    return a != a;
`endif
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    int w;
    w = word_of(a);
    if (!out_of_range(a)) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bit oob;
    oob = out_of_range(a);
    check("wr_while_busy", 32'(busy0 | busy3), 32'd0);
    sram_wen = m;
    sram_address = a;
    sram_data_write = d;
    step();
    sram_wen = 4'd0;
    model_write(a, m, d);
    check("berr0_wr", 32'(berr0), 32'(oob));
    check("berr3_wr", 32'(berr3), 32'(oob));
  endtask

  // Read with an optional same-cycle write; checks the whole response window.
  task automatic do_read(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bit oob;
    logic [31:0] exp;
    oob = out_of_range(a);
    check("rd_while_busy", 32'(busy0 | busy3), 32'd0);
    model_write(a, m, d);
    exp = oob ? 32'hDEAD_BEEF : model_mem[word_of(a)];
    sram_ren = 1'b1;
    sram_wen = m;
    sram_address = a;
    sram_data_write = d;
    step();
    sram_ren = 1'b0;
    sram_wen = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      check("rack0", 32'(rack0), 32'(k == 1));
      check("busy0", 32'(busy0), 32'(k == 1));
      check("rack3", 32'(rack3), 32'(k == 4));
      check("busy3", 32'(busy3), 32'(k <= 4));
      check("data0", rdata0, exp);
      check("data3", rdata3, (k < 4) ? last3 : exp);
      if (k == 1) begin
        check("berr0_rd", 32'(berr0), 32'(oob));
        check("berr3_rd", 32'(berr3), 32'(oob));
      end
      step();
    end
    last3 = exp;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    rst = 1'b0;
    sram_ren = 1'b0;
    sram_wen = 4'd0;
    sram_address = 32'd0;
    sram_data_write = 32'd0;
    last3 = 32'd0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'hx;

    step(); step(); step();
    check("rst_rack0", 32'(rack0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_data0", rdata0, 32'd0);
    check("rst_berr0", 32'(berr0), 32'd0);
    check("rst_rack3", 32'(rack3), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_data3", rdata3, 32'd0);
    check("rst_berr3", 32'(berr3), 32'd0);
    rst = 1'b1;
    step();

    // Basic readback.
    do_write(32'h10, 4'hF, 32'h1234_5678);
    do_read(32'h10, 4'h0, 32'h0);
    check("tp_readback", rdata0, 32'h1234_5678);

    // Byte lanes.
    do_write(32'h20, 4'hF, 32'hFFFF_FFFF);
    do_write(32'h20, 4'b0100, 32'h00AB_0000);
    do_read(32'h20, 4'h0, 32'h0);
    check("tp_lanes", rdata3, 32'hFFAB_FFFF);

    // Same-word read and write together: write-first.
    do_write(32'h30, 4'hF, 32'h1111_1111);
    do_read(32'h30, 4'b0001, 32'h0000_00EE);
    check("tp_rw_same", rdata0, 32'h1111_11EE);

    // Reset in the middle of a WAIT_STATES=3 read.
    sram_ren = 1'b1;
    sram_address = 32'h10;
    step();
    sram_ren = 1'b0;
    check("mid_busy3", 32'(busy3), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("mid_rack3", 32'(rack3), 32'd0);
    check("mid_busy3_rst", 32'(busy3), 32'd0);
    check("mid_data3", rdata3, 32'd0);
    check("mid_data0", rdata0, 32'd0);
    rst = 1'b1;
    last3 = 32'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_no_rack3", 32'(rack3), 32'd0);
    end
    do_read(32'h10, 4'h0, 32'h0);
    check("mid_after", rdata3, 32'h1234_5678);

    // Window edge: bounds-checked or wrapping.
    do_write(32'h0, 4'hF, 32'hA5A5_A5A5);
`ifdef DMEM_BOUNDS_CHECK_EN
    do_read(32'h1000, 4'h0, 32'h0);
    check("oob_read", rdata0, 32'hDEAD_BEEF);
    do_write(32'h1000, 4'hF, 32'h0);
    do_read(32'h0, 4'h0, 32'h0);
    check("oob_wr_drop", rdata3, 32'hA5A5_A5A5);
`else
    do_write(32'h1000, 4'hF, 32'h5A5A_5A5A);
    do_read(32'h0, 4'h0, 32'h0);
    check("wrap_alias", rdata3, 32'h5A5A_5A5A);
`endif

    // Randomized traffic over a small pool of words.
    for (int i = 0; i < 32; i++)
      do_write(32'h100 + 32'(4 * i), 4'hF, $urandom);
    for (int n = 0; n < 80; n++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'(32'h1000 * $urandom_range(1, 3));
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0)
        do_write(a, m, $urandom);
      else if ($urandom_range(0, 3) == 0)
        do_read(a, m, $urandom);
      else
        do_read(a, 4'h0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
